// File: rtl/spi_pkg.sv
// spi_pkg: shared types and default configuration for the SPI burst master.
package spi_pkg;

  // Controller states of the burst master.
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    SHIFT = 3'd2,
    NEXT  = 3'd3,
    HOLD  = 3'd4
  } spi_state_t;

  localparam int SPI_DATA_W_DEF = 8;
  localparam int SPI_DIV_W_DEF  = 8;
  localparam bit SPI_CPOL_DEF   = 1'b0;
  localparam bit SPI_CPHA_DEF   = 1'b0;

  // True when an sclk edge is the one on which mosi advances.
  // With CPHA=0 data moves on trailing edges, with CPHA=1 on leading edges;
  // the other edge is always the sampling edge.
  function automatic logic mosi_edge(input logic cpha, input logic leading);
    return (cpha == leading);
  endfunction

endpackage

// File: rtl/spi_clk_div.sv
// spi_clk_div: produces a one-cycle tick every div+1 clk cycles. The divisor
// is captured on restart so later changes on div_i are ignored until the next
// restart, and the phase is realigned so the first tick lands div+1 cycles on.
module spi_clk_div
  import spi_pkg::*;
#(
  parameter int DIV_W = SPI_DIV_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             restart_i,
  input  logic [DIV_W-1:0] div_i,
  output logic             tick_o
);

  logic [DIV_W-1:0] div_q;
  logic [DIV_W-1:0] cnt_q;
  logic [DIV_W-1:0] cnt_d;

  assign tick_o = (cnt_q == div_q) && !restart_i;

  // Next count: wrap on tick, otherwise advance.
  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (tick_o) cnt_d = '0;
  end

  // Divisor latch and free-running half-period counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_q <= '0;
      cnt_q <= '0;
    end else if (restart_i) begin
      div_q <= div_i;
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/spi_burst_master.sv
// spi_burst_master: SPI master that streams bursts of DATA_W-bit words (MSB
// first) to an ILI9341-style display. cs_n stays low across every word of a
// burst and is released after the word flagged last; dc follows each word.
// Build option: define SPI_MASTER_RX_EN to add the receive path
// (miso, rx_data, rx_valid).
module spi_burst_master
  import spi_pkg::*;
#(
  parameter int DATA_W = SPI_DATA_W_DEF,
  parameter int DIV_W  = SPI_DIV_W_DEF,
  parameter bit CPOL   = SPI_CPOL_DEF,
  parameter bit CPHA   = SPI_CPHA_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DIV_W-1:0]  clk_div,
  input  logic              tx_valid,
  output logic              tx_ready,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_dc,
  input  logic              tx_last,
  output logic              busy,
  output logic              done,
  output logic              sclk,
  output logic              mosi,
  output logic              cs_n,
  output logic              dc
`ifdef SPI_MASTER_RX_EN
  ,
  input  logic              miso,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid
`endif
);

  // Edge counter spans the 2*DATA_W sclk toggles of one word.
  localparam int EDGE_W = $clog2(2 * DATA_W);
  localparam logic [EDGE_W-1:0] LAST_EDGE = EDGE_W'(2 * DATA_W - 1);

  spi_state_t        state_q;
  logic [EDGE_W-1:0] edge_q;
  logic [DATA_W-1:0] sh_q;
  logic              last_q;
  logic              sclk_q;
  logic              mosi_q;
  logic              cs_n_q;
  logic              dc_q;
  logic              tx_ready_q;
  logic              busy_q;
  logic              done_q;

  logic tick;
  logic accept;
  logic leading;
  logic adv_edge;
  logic word_end;

  // tx_ready is only ever high in IDLE and NEXT, so accept implies one of those.
  assign accept   = tx_valid && tx_ready_q;
  // A toggle away from the idle level is the leading edge of a bit.
  assign leading  = (sclk_q == CPOL);
  assign adv_edge = mosi_edge(CPHA, leading);
  assign word_end = (state_q == SHIFT) && tick && (edge_q == LAST_EDGE);

  spi_clk_div #(
    .DIV_W (DIV_W)
  ) u_clk_div (
    .clk       (clk),
    .rst       (rst),
    .restart_i (accept),
    .div_i     (clk_div),
    .tick_o    (tick)
  );

  // Burst controller: state, pin levels and handshake, all registered.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      edge_q     <= '0;
      sh_q       <= '0;
      last_q     <= 1'b0;
      sclk_q     <= CPOL;
      mosi_q     <= 1'b0;
      cs_n_q     <= 1'b1;
      dc_q       <= 1'b0;
      tx_ready_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE, NEXT: begin
          tx_ready_q <= 1'b1;
          if (accept) begin
            state_q    <= SETUP;
            tx_ready_q <= 1'b0;
            busy_q     <= 1'b1;
            cs_n_q     <= 1'b0;
            dc_q       <= tx_dc;
            last_q     <= tx_last;
            edge_q     <= '0;
            sclk_q     <= CPOL;
            if (!CPHA) begin
              // MSB must already be on the line for the first leading edge.
              mosi_q <= tx_data[DATA_W-1];
              sh_q   <= tx_data << 1;
            end else begin
              sh_q <= tx_data;
            end
          end
        end
        SETUP: begin
          if (tick) state_q <= SHIFT;
        end
        SHIFT: begin
          if (tick) begin
            sclk_q <= ~sclk_q;
            edge_q <= edge_q + 1'b1;
            // The final toggle closes the word; no further bit is presented.
            if (adv_edge && (edge_q != LAST_EDGE)) begin
              mosi_q <= sh_q[DATA_W-1];
              sh_q   <= sh_q << 1;
            end
            if (edge_q == LAST_EDGE) begin
              edge_q <= '0;
              if (last_q) begin
                state_q <= HOLD;
              end else begin
                state_q    <= NEXT;
                tx_ready_q <= 1'b1;
              end
            end
          end
        end
        HOLD: begin
          if (tick) begin
            state_q    <= IDLE;
            busy_q     <= 1'b0;
            cs_n_q     <= 1'b1;
            done_q     <= 1'b1;
            tx_ready_q <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef SPI_MASTER_RX_EN
  logic [DATA_W-1:0] rx_sh_q;
  logic [DATA_W-1:0] rx_data_q;
  logic              rx_valid_q;
  logic [DATA_W-1:0] rx_next;
  logic              sample;

  assign sample  = (state_q == SHIFT) && tick && !adv_edge;
  assign rx_next = {rx_sh_q[DATA_W-2:0], miso};

  // Receive shifter: capture miso on sampling edges, publish at word end.
  // With CPHA=1 the last sample coincides with word end, so use rx_next.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_sh_q    <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
    end else begin
      rx_valid_q <= 1'b0;
      if (sample) rx_sh_q <= rx_next;
      if (word_end) begin
        rx_valid_q <= 1'b1;
        rx_data_q  <= CPHA ? rx_next : rx_sh_q;
      end
    end
  end

  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;
`endif

  assign tx_ready = tx_ready_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign sclk     = sclk_q;
  assign mosi     = mosi_q;
  assign cs_n     = cs_n_q;
  assign dc       = dc_q;

endmodule

// File: tb/tb_spi_burst_master.sv
// tb_spi_burst_master: two masters (CPOL0/CPHA0 and CPOL1/CPHA1) driven from
// shared stimulus. A slave model watches the selected master's pins and
// reassembles words; the bench compares those against what it sent.
`timescale 1ns/1ps
module tb_spi_burst_master;

  localparam int W = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [7:0] clk_div = 8'd0;
  logic [W-1:0] tx_data = '0;
  logic tx_dc = 1'b0, tx_last = 1'b0;
  logic tx_valid_a = 1'b0, tx_valid_b = 1'b0;
  logic tx_ready_a, busy_a, done_a, sclk_a, mosi_a, cs_n_a, dc_a;
  logic tx_ready_b, busy_b, done_b, sclk_b, mosi_b, cs_n_b, dc_b;
`ifdef SPI_MASTER_RX_EN
  logic [W-1:0] rxd_a, rxd_b;
  logic rxv_a, rxv_b;
`endif

  always #5 clk = ~clk;

  spi_burst_master #(.DATA_W(W), .DIV_W(8), .CPOL(1'b0), .CPHA(1'b0)) dut_a (
    .clk(clk), .rst(rst), .clk_div(clk_div), .tx_valid(tx_valid_a), .tx_ready(tx_ready_a),
    .tx_data(tx_data), .tx_dc(tx_dc), .tx_last(tx_last), .busy(busy_a), .done(done_a),
    .sclk(sclk_a), .mosi(mosi_a), .cs_n(cs_n_a), .dc(dc_a)
`ifdef SPI_MASTER_RX_EN
    , .miso(mosi_a), .rx_data(rxd_a), .rx_valid(rxv_a)
`endif
  );

  spi_burst_master #(.DATA_W(W), .DIV_W(8), .CPOL(1'b1), .CPHA(1'b1)) dut_b (
    .clk(clk), .rst(rst), .clk_div(clk_div), .tx_valid(tx_valid_b), .tx_ready(tx_ready_b),
    .tx_data(tx_data), .tx_dc(tx_dc), .tx_last(tx_last), .busy(busy_b), .done(done_b),
    .sclk(sclk_b), .mosi(mosi_b), .cs_n(cs_n_b), .dc(dc_b)
`ifdef SPI_MASTER_RX_EN
    , .miso(mosi_b), .rx_data(rxd_b), .rx_valid(rxv_b)
`endif
  );

  // Pins of the currently observed master (sel=1 selects CPOL1/CPHA1).
  logic sel = 1'b0;
  logic sclk_m, mosi_m, cs_m, dc_m, done_m, rdy_m, txv_m, busy_m;
  assign sclk_m = sel ? sclk_b : sclk_a;
  assign mosi_m = sel ? mosi_b : mosi_a;
  assign cs_m   = sel ? cs_n_b : cs_n_a;
  assign dc_m   = sel ? dc_b : dc_a;
  assign done_m = sel ? done_b : done_a;
  assign rdy_m  = sel ? tx_ready_b : tx_ready_a;
  assign txv_m  = sel ? tx_valid_b : tx_valid_a;
  assign busy_m = sel ? busy_b : busy_a;
`ifdef SPI_MASTER_RX_EN
  logic rxv_m;
  logic [W-1:0] rxd_m;
  assign rxv_m = sel ? rxv_b : rxv_a;
  assign rxd_m = sel ? rxd_b : rxd_a;
`endif

  // Slave model and protocol counters (written only by the monitor below).
  int n_rise = 0, n_done = 0, n_cs_low = 0, n_cs_rise = 0;
  int n_idle_bad = 0, n_mosi_bad = 0, n_dc_bad = 0, cap_cnt = 0;
  logic [W-1:0] cap_word [0:255];
  logic cap_dc [0:255];
`ifdef SPI_MASTER_RX_EN
  int n_rxv = 0;
  logic [W-1:0] rx_last = '0;
`endif

  initial begin
    logic p_sel, p_sclk, p_mosi, p_cs, p_acc, edge_now, lead, samp, wdc;
    logic [W-1:0] sreg;
    int bitcnt;
    p_sel = 1'b0; p_sclk = 1'b0; p_mosi = 1'b0; p_cs = 1'b1; p_acc = 1'b0;
    sreg = '0; bitcnt = 0; wdc = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst || sel != p_sel) begin
        bitcnt = 0;
      end else begin
        if (done_m) n_done++;
        if (!cs_m) n_cs_low++;
        if (cs_m && !p_cs) n_cs_rise++;
        if (cs_m && sclk_m != sel) n_idle_bad++;
        if (cs_m) bitcnt = 0;
        edge_now = (sclk_m != p_sclk);
        lead     = edge_now && (p_sclk == sel);
        samp     = edge_now && (lead != sel);
        if (edge_now && sclk_m && !p_sclk) n_rise++;
        // mosi may move only on the non-sampling edge or right after an accept
        if (mosi_m != p_mosi && !p_cs && !cs_m && !p_acc && !(edge_now && !samp)) n_mosi_bad++;
        if (samp && !cs_m) begin
          if (bitcnt == 0) wdc = dc_m;
          else if (dc_m != wdc) n_dc_bad++;
          sreg = {sreg[W-2:0], mosi_m};
          bitcnt++;
          if (bitcnt == W) begin
            if (cap_cnt < 256) begin
              cap_word[cap_cnt] = sreg;
              cap_dc[cap_cnt]   = wdc;
            end
            cap_cnt++;
            bitcnt = 0;
          end
        end
`ifdef SPI_MASTER_RX_EN
        if (rxv_m) begin
          n_rxv++;
          rx_last = rxd_m;
        end
`endif
      end
      p_sel = sel; p_sclk = sclk_m; p_mosi = mosi_m; p_cs = cs_m;
      p_acc = txv_m && rdy_m;
    end
  end

  int n_tests = 0, n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic select_dut(input logic s);
    @(posedge clk); #1;
    sel = s;
    repeat (2) @(posedge clk);
  endtask

  // Offer one word and hold it until accepted, then scramble the inputs so a
  // master that keeps looking at them would misbehave.
  task automatic send_word(input logic [W-1:0] d, input logic dcv, input logic last,
                           input logic [7:0] div);
    logic ok;
    @(posedge clk); #1;
    tx_data = d; tx_dc = dcv; tx_last = last; clk_div = div;
    if (sel) tx_valid_b = 1'b1; else tx_valid_a = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      if (rdy_m) begin ok = 1'b1; break; end
    end
    check("accept", ok, 1);
    @(posedge clk); #1;
    tx_valid_a = 1'b0; tx_valid_b = 1'b0;
    tx_data = W'($urandom); tx_dc = 1'($urandom); tx_last = 1'($urandom);
    clk_div = 8'($urandom);
  endtask

  task automatic wait_done();
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 5000; i++) begin
      @(negedge clk);
      if (done_m) begin seen = 1'b1; break; end
    end
    check("done_seen", seen, 1);
    repeat (3) @(posedge clk);
  endtask

  typedef struct {
    logic         s;
    logic [W-1:0] d;
    logic         dc;
    logic [7:0]   div;
    int           exp_rise;
    int           exp_cs_low;
  } vec_t;

  // Single word: SETUP + 2*W half-periods + HOLD, each div+1 cycles long.
  function automatic vec_t mk(input logic s, input logic [W-1:0] d, input logic dcv,
                              input logic [7:0] div);
    vec_t v;
    v.s = s; v.d = d; v.dc = dcv; v.div = div;
    v.exp_rise   = W;
    v.exp_cs_low = (2 * W + 2) * (int'(div) + 1);
    return v;
  endfunction

  vec_t vt [6];
  int b_rise, b_cs, b_done, b_cap, b_bad, b_csr, bad, len;
  logic [W-1:0] exp_w [4];
  logic exp_dc [4];
  logic s;
  logic ok;
`ifdef SPI_MASTER_RX_EN
  int b_rxv;
`endif

  initial begin
    vt[0] = mk(1'b0, 8'hA5, 1'b0, 8'd1);
    vt[1] = mk(1'b1, 8'h81, 1'b1, 8'd0);
    vt[2] = mk(1'b0, 8'hFF, 1'b1, 8'd0);
    vt[3] = mk(1'b1, 8'h00, 1'b0, 8'd2);
    vt[4] = mk(1'b0, 8'h3C, 1'b0, 8'd3);
    vt[5] = mk(1'b1, 8'h5A, 1'b1, 8'd1);

    // Reset values while held, then tx_ready on the first edge after release.
    repeat (3) @(posedge clk); #1;
    check("rst_cs_n", cs_n_a, 1);
    check("rst_sclk_a", sclk_a, 0);
    check("rst_sclk_b", sclk_b, 1);
    check("rst_mosi", mosi_a, 0);
    check("rst_dc", dc_a, 0);
    check("rst_ready", tx_ready_a, 0);
    check("rst_busy", busy_a, 0);
    check("rst_done", done_a, 0);
    @(negedge clk); #1;
    rst = 1'b1;
    #1;
    check("ready_before_edge", tx_ready_a, 0);
    @(negedge clk);
    check("ready_after_edge_a", tx_ready_a, 1);
    check("ready_after_edge_b", tx_ready_b, 1);

    // Single-word table.
    for (int i = 0; i < 6; i++) begin
      select_dut(vt[i].s);
      b_rise = n_rise; b_cs = n_cs_low; b_done = n_done; b_cap = cap_cnt;
      b_bad = n_mosi_bad + n_idle_bad + n_dc_bad;
`ifdef SPI_MASTER_RX_EN
      b_rxv = n_rxv;
`endif
      send_word(vt[i].d, vt[i].dc, 1'b1, vt[i].div);
      wait_done();
      check("word", cap_word[b_cap], vt[i].d);
      check("word_dc", cap_dc[b_cap], vt[i].dc);
      check("word_count", cap_cnt - b_cap, 1);
      check("sclk_rises", n_rise - b_rise, vt[i].exp_rise);
      check("cs_low_cycles", n_cs_low - b_cs, vt[i].exp_cs_low);
      check("done_pulses", n_done - b_done, 1);
      check("dc_kept_idle", dc_m, vt[i].dc);
      check("busy_idle", busy_m, 0);
      check("protocol", n_mosi_bad + n_idle_bad + n_dc_bad - b_bad, 0);
`ifdef SPI_MASTER_RX_EN
      check("rx_pulses", n_rxv - b_rxv, 1);
      check("rx_data", rx_last, vt[i].d);
`endif
    end

    // Three-word burst with a dc switch after the command word.
    select_dut(1'b0);
    b_done = n_done; b_cap = cap_cnt; b_csr = n_cs_rise;
    send_word(8'h2C, 1'b0, 1'b0, 8'd1);
    send_word(8'h12, 1'b1, 1'b0, 8'd1);
    send_word(8'h34, 1'b1, 1'b1, 8'd1);
    wait_done();
    check("burst_w0", cap_word[b_cap], 8'h2C);
    check("burst_w1", cap_word[b_cap + 1], 8'h12);
    check("burst_w2", cap_word[b_cap + 2], 8'h34);
    check("burst_dc0", cap_dc[b_cap], 0);
    check("burst_dc1", cap_dc[b_cap + 1], 1);
    check("burst_dc2", cap_dc[b_cap + 2], 1);
    check("burst_cs_rises", n_cs_rise - b_csr, 1);
    check("burst_done", n_done - b_done, 1);

    // Long stall between words: the bus must hold still with cs_n asserted.
    select_dut(1'b1);
    b_done = n_done; b_cap = cap_cnt;
    send_word(8'hC3, 1'b0, 1'b0, 8'd1);
    ok = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (rdy_m) begin ok = 1'b1; break; end
    end
    check("next_reached", ok, 1);
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (cs_m !== 1'b0 || sclk_m !== sel || rdy_m !== 1'b1 || done_m !== 1'b0) bad++;
    end
    check("next_stall", bad, 0);
    check("next_no_done", n_done - b_done, 0);
    send_word(8'h77, 1'b1, 1'b1, 8'd0);
    wait_done();
    check("stall_w0", cap_word[b_cap], 8'hC3);
    check("stall_w1", cap_word[b_cap + 1], 8'h77);
    check("stall_done", n_done - b_done, 1);

    // Asynchronous reset in the middle of a word.
    select_dut(1'b0);
    b_done = n_done; b_cap = cap_cnt;
    send_word(8'hF0, 1'b0, 1'b1, 8'd1);
    repeat (8) @(posedge clk); #3;
    check("busy_mid_word", busy_a, 1);
    check("cs_low_mid_word", cs_n_a, 0);
    rst = 1'b0;
    #1;
    check("abort_cs_n", cs_n_a, 1);
    check("abort_sclk", sclk_a, 0);
    check("abort_busy", busy_a, 0);
    check("abort_ready", tx_ready_a, 0);
    repeat (2) @(posedge clk); #3;
    rst = 1'b1;
    repeat (6) @(posedge clk);
    check("abort_no_done", n_done - b_done, 0);
    check("abort_no_word", cap_cnt - b_cap, 0);
    send_word(8'h0F, 1'b0, 1'b1, 8'd1);
    wait_done();
    check("after_abort_word", cap_word[b_cap], 8'h0F);
    check("after_abort_done", n_done - b_done, 1);

    // Random bursts against the word/dc queue model.
    for (int b = 0; b < 20; b++) begin
      s = 1'($urandom_range(0, 1));
      select_dut(s);
      len = $urandom_range(1, 4);
      b_done = n_done; b_cap = cap_cnt; b_csr = n_cs_rise;
      b_bad = n_mosi_bad + n_idle_bad + n_dc_bad;
`ifdef SPI_MASTER_RX_EN
      b_rxv = n_rxv;
`endif
      for (int w = 0; w < len; w++) begin
        exp_w[w]  = W'($urandom);
        exp_dc[w] = 1'($urandom);
        repeat ($urandom_range(0, 3)) @(posedge clk);
        send_word(exp_w[w], exp_dc[w], w == len - 1, 8'($urandom_range(0, 3)));
      end
      wait_done();
      check("rnd_count", cap_cnt - b_cap, len);
      for (int w = 0; w < len; w++) begin
        check("rnd_word", cap_word[b_cap + w], exp_w[w]);
        check("rnd_dc", cap_dc[b_cap + w], exp_dc[w]);
      end
      check("rnd_done", n_done - b_done, 1);
      check("rnd_cs_rises", n_cs_rise - b_csr, 1);
      check("rnd_dc_idle", dc_m, exp_dc[len - 1]);
      check("rnd_protocol", n_mosi_bad + n_idle_bad + n_dc_bad - b_bad, 0);
`ifdef SPI_MASTER_RX_EN
      check("rnd_rx_pulses", n_rxv - b_rxv, len);
      check("rnd_rx_data", rx_last, exp_w[len - 1]);
`endif
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, %0d tests run", n_tests);
    $fatal(1, "watchdog");
  end

endmodule
